// File: rtl/gcm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : gcm_pkg                                                      |
// | Description : Shared constants, FSM state encoding and length-block        |
// |               builder for the GHASH input formatter.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package gcm_pkg;

  // GHASH block width; the formatter only supports 128-bit blocks.
  localparam int GCM_NB_BLOCK = 128;
  // Width of each bit-length counter.
  localparam int GCM_NB_LEN   = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AAD  = 2'd1,
    ST_TEXT = 2'd2,
    ST_LEN  = 2'd3
  } fmt_state_t;

  // Final GHASH block: len(A) in the upper half, len(C) in the lower half.
  function automatic logic [2*GCM_NB_LEN-1:0] build_len_block(
    input logic [GCM_NB_LEN-1:0] len_a,
    input logic [GCM_NB_LEN-1:0] len_c
  );
    return {len_a, len_c};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ghash_block_pad.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ghash_block_pad                                              |
// | Description : Combinational zero-pad of one big-endian GHASH block.        |
// |               Keeps the first i_nbytes bytes (byte 0 at the MSBs) and      |
// |               clears the rest; i_nbytes = 0 means the block is full.       |
// | Ports       : i_block  - raw block                                         |
// |               i_nbytes - bytes to keep (0 = 16)                            |
// |               o_block  - padded block                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ghash_block_pad
  import gcm_pkg::*;
#(
  parameter int NB_BLOCK = GCM_NB_BLOCK
) (
  input  logic [NB_BLOCK-1:0] i_block,
  input  logic [3:0]          i_nbytes,
  output logic [NB_BLOCK-1:0] o_block
);

  logic [NB_BLOCK-1:0] w_low_ones;
  logic [NB_BLOCK-1:0] w_keep;

  always_comb begin
    // Ones below the kept bytes; inverting gives the mask of kept MSBs.
    w_low_ones = {NB_BLOCK{1'b1}} >> {i_nbytes, 3'b000};
    w_keep     = (i_nbytes == 4'd0) ? {NB_BLOCK{1'b1}} : ~w_low_ones;
  end

  assign o_block = i_block & w_keep;

endmodule
`default_nettype wire

// File: rtl/ghash_input_formatter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ghash_input_formatter                                        |
// | Description : Feeds the multi-block GHASH stage. Accepts AAD then          |
// |               ciphertext words, zero-pads partial blocks, counts bit       |
// |               lengths and appends the len(A)||len(C) block. All outputs    |
// |               are registered; one cycle latency, one bubble only when the  |
// |               length block needs its own word.                             |
// | Ports       : i_clock/i_reset (sync, active-high)                          |
// |               i_data_bus, i_valid, i_sop, i_is_aad, i_seg_last, i_eop,     |
// |               i_blk_mask, i_last_nbytes  - input word stream               |
// |               o_ready                    - input handshake                 |
// |               o_data_x_bus, o_valid, o_sop, o_skip_bus, o_last - to GHASH  |
// |               o_proto_err                - sticky protocol error           |
// | Options     : GHASH_FMT_PROTOCOL_CHECK_EN enables protocol checking; when  |
// |               undefined o_proto_err is 0. NB_BLOCK must be 128.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ghash_input_formatter
  import gcm_pkg::*;
#(
  parameter int NB_BLOCK      = GCM_NB_BLOCK,
  parameter int N_BLOCKS      = 2,
  parameter int LOG2_N_BLOCKS = 1,
  parameter int NB_DATA       = N_BLOCKS * NB_BLOCK,
  parameter int NB_LEN        = GCM_NB_LEN
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NB_DATA-1:0]  i_data_bus,
  input  logic                i_valid,
  input  logic                i_sop,
  input  logic                i_is_aad,
  input  logic                i_seg_last,
  input  logic                i_eop,
  input  logic [N_BLOCKS-1:0] i_blk_mask,
  input  logic [3:0]          i_last_nbytes,
  output logic                o_ready,
  output logic [NB_DATA-1:0]  o_data_x_bus,
  output logic                o_valid,
  output logic                o_sop,
  output logic [N_BLOCKS-1:0] o_skip_bus,
  output logic                o_last,
  output logic                o_proto_err
);

  fmt_state_t          state_q, state_d;
  logic [NB_LEN-1:0]   len_a_q, len_a_d;
  logic [NB_LEN-1:0]   len_c_q, len_c_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic                sop_q, sop_d;
  logic                last_q, last_d;
  logic [N_BLOCKS-1:0] skip_q, skip_d;
  logic [NB_DATA-1:0]  data_q, data_d;
  logic                proto_err_q, proto_err_d;

  logic                  w_word_last;
  logic [N_BLOCKS-1:0]   w_top;
  logic [3:0]            w_blk_nbytes [N_BLOCKS];
  logic [NB_DATA-1:0]    w_padded;
  logic [NB_LEN-1:0]     w_contrib;
  logic [LOG2_N_BLOCKS:0] w_nvalid;
  logic                  w_has_free;
  logic                  w_fire;
  logic                  w_viol;
  logic                  w_accept;
  logic [NB_LEN-1:0]     w_base_a;
  logic [NB_LEN-1:0]     w_base_c;

  // The last word of either segment carries the partial-byte count.
  assign w_word_last = i_seg_last | i_eop;

  // Per-block padding; only the highest valid block of a segment's last
  // word can be partial, invalid blocks are zeroed.
  for (genvar k = 0; k < N_BLOCKS; k++) begin : g_pad
    logic [NB_BLOCK-1:0] w_blk_out;

    if (k == N_BLOCKS - 1) begin : g_top_hi
      assign w_top[k] = i_blk_mask[k];
    end else begin : g_top_lo
      assign w_top[k] = i_blk_mask[k] & ~i_blk_mask[k+1];
    end

    assign w_blk_nbytes[k] = (w_word_last && w_top[k]) ? i_last_nbytes : 4'd0;

    ghash_block_pad #(
      .NB_BLOCK (NB_BLOCK)
    ) u_pad (
      .i_block  (i_data_bus[k*NB_BLOCK +: NB_BLOCK]),
      .i_nbytes (w_blk_nbytes[k]),
      .o_block  (w_blk_out)
    );

    assign w_padded[k*NB_BLOCK +: NB_BLOCK] = i_blk_mask[k] ? w_blk_out : '0;
  end

  // Bit contribution of this word and number of valid blocks.
  always_comb begin
    w_contrib = '0;
    w_nvalid  = '0;
    for (int k = 0; k < N_BLOCKS; k++) begin
      if (i_blk_mask[k]) begin
        w_nvalid = w_nvalid + {{LOG2_N_BLOCKS{1'b0}}, 1'b1};
        if (w_blk_nbytes[k] != 4'd0) begin
          w_contrib = w_contrib + {{(NB_LEN-7){1'b0}}, w_blk_nbytes[k], 3'b000};
        end else begin
          w_contrib = w_contrib + NB_LEN'(NB_BLOCK);
        end
      end
    end
  end

  // Mask is contiguous from bit 0, so the lowest free slot index equals
  // the number of valid blocks.
  assign w_has_free = (int'(w_nvalid) < N_BLOCKS);

  assign w_fire = i_valid & ready_q;

`ifdef GHASH_FMT_PROTOCOL_CHECK_EN
  logic [N_BLOCKS:0] w_mask_inc;
  logic              w_contig;

  assign w_mask_inc = {1'b0, i_blk_mask} + {{N_BLOCKS{1'b0}}, 1'b1};
  // Contiguous-from-0 masks have no bit in common with mask+1.
  assign w_contig   = (({1'b0, i_blk_mask} & w_mask_inc) == '0);

  assign w_viol = ((state_q == ST_IDLE) && !i_sop)
                | ((state_q != ST_IDLE) && i_sop)
                | ((state_q == ST_TEXT) && i_is_aad)
                | !w_contig
                | ((i_blk_mask == '0) && !i_eop)
                | (!w_word_last && (i_blk_mask != {N_BLOCKS{1'b1}}));
`else
  assign w_viol = 1'b0;
`endif

  assign w_accept = w_fire & ~w_viol;

  // Counters restart at the first word of a message.
  assign w_base_a = i_sop ? '0 : len_a_q;
  assign w_base_c = i_sop ? '0 : len_c_q;

  always_comb begin
    state_d     = state_q;
    len_a_d     = len_a_q;
    len_c_d     = len_c_q;
    ready_d     = 1'b1;
    valid_d     = 1'b0;
    sop_d       = 1'b0;
    last_d      = 1'b0;
    skip_d      = {N_BLOCKS{1'b1}};
    data_d      = '0;
    proto_err_d = proto_err_q | (w_fire & w_viol);

    if (state_q == ST_LEN) begin
      // Stand-alone length word after a full i_eop word.
      valid_d                = 1'b1;
      last_d                 = 1'b1;
      data_d[0 +: NB_BLOCK]  = build_len_block(len_a_q, len_c_q);
      skip_d[0]              = 1'b0;
      state_d                = ST_IDLE;
    end else if (w_accept) begin
      if (i_is_aad) begin
        len_a_d = w_base_a + w_contrib;
        len_c_d = w_base_c;
      end else begin
        len_a_d = w_base_a;
        len_c_d = w_base_c + w_contrib;
      end

      valid_d = 1'b1;
      sop_d   = i_sop;
      data_d  = w_padded;
      skip_d  = ~i_blk_mask;

      if (i_eop) begin
        if (w_has_free) begin
          for (int k = 0; k < N_BLOCKS; k++) begin
            if (int'(w_nvalid) == k) begin
              data_d[k*NB_BLOCK +: NB_BLOCK] = build_len_block(len_a_d, len_c_d);
              skip_d[k]                      = 1'b0;
            end
          end
          last_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ready_d = 1'b0;
          state_d = ST_LEN;
        end
      end else if (i_is_aad && !i_seg_last) begin
        state_d = ST_AAD;
      end else begin
        state_d = ST_TEXT;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      len_a_q     <= '0;
      len_c_q     <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      last_q      <= 1'b0;
      skip_q      <= {N_BLOCKS{1'b1}};
      data_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_a_q     <= len_a_d;
      len_c_q     <= len_c_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      sop_q       <= sop_d;
      last_q      <= last_d;
      skip_q      <= skip_d;
      data_q      <= data_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_valid      = valid_q;
  assign o_sop        = sop_q;
  assign o_last       = last_q;
  assign o_skip_bus   = skip_q;
  assign o_data_x_bus = data_q;
  assign o_proto_err  = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ghash_input_formatter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ghash_input_formatter                                     |
// | Description : Self-checking bench for ghash_input_formatter. Expected      |
// |               output words are queued as stimulus is driven and compared   |
// |               as the design emits them.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ghash_input_formatter;

  typedef struct {
    logic [255:0] data;
    logic         sop;
    logic [1:0]   skip;
    logic         last;
  } exp_t;

  logic         i_clock = 1'b0;
  logic         i_reset;
  logic [255:0] i_data_bus;
  logic         i_valid;
  logic         i_sop;
  logic         i_is_aad;
  logic         i_seg_last;
  logic         i_eop;
  logic [1:0]   i_blk_mask;
  logic [3:0]   i_last_nbytes;
  logic         o_ready;
  logic [255:0] o_data_x_bus;
  logic         o_valid;
  logic         o_sop;
  logic [1:0]   o_skip_bus;
  logic         o_last;
  logic         o_proto_err;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  ghash_input_formatter dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_data_bus    (i_data_bus),
    .i_valid       (i_valid),
    .i_sop         (i_sop),
    .i_is_aad      (i_is_aad),
    .i_seg_last    (i_seg_last),
    .i_eop         (i_eop),
    .i_blk_mask    (i_blk_mask),
    .i_last_nbytes (i_last_nbytes),
    .o_ready       (o_ready),
    .o_data_x_bus  (o_data_x_bus),
    .o_valid       (o_valid),
    .o_sop         (o_sop),
    .o_skip_bus    (o_skip_bus),
    .o_last        (o_last),
    .o_proto_err   (o_proto_err)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Byte-wise reference padding: keep bytes 0..n-1 (byte 0 at MSBs).
  function automatic logic [127:0] pad_ref(input logic [127:0] b, input int n);
    logic [127:0] r;
    r = b;
    if (n != 0) begin
      for (int i = n; i < 16; i++) r[127-8*i -: 8] = 8'h00;
    end
    return r;
  endfunction

  function automatic void push_exp(input logic [255:0] d, input logic s,
                                   input logic [1:0] sk, input logic l);
    exp_t e;
    e.data = d; e.sop = s; e.skip = sk; e.last = l;
    sb.push_back(e);
  endfunction

  // Output monitor: every valid word must match the next expected word.
  always @(posedge i_clock) begin
    #1;
    if (o_valid !== 1'b0) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output valid=%b sop=%b last=%b skip=%b required=no_output",
                 o_valid, o_sop, o_last, o_skip_bus);
      end else begin
        mon_e = sb.pop_front();
        if (o_data_x_bus !== mon_e.data) begin
          n_err++;
          $display("FAIL out_data got=%h required=%h", o_data_x_bus, mon_e.data);
        end
        n_vec++;
        if (o_sop !== mon_e.sop) begin
          n_err++;
          $display("FAIL out_sop got=%b required=%b", o_sop, mon_e.sop);
        end
        n_vec++;
        if (o_skip_bus !== mon_e.skip) begin
          n_err++;
          $display("FAIL out_skip got=%b required=%b", o_skip_bus, mon_e.skip);
        end
        n_vec++;
        if (o_last !== mon_e.last) begin
          n_err++;
          $display("FAIL out_last got=%b required=%b", o_last, mon_e.last);
        end
      end
    end
  end

  // Present one word from a falling edge; returns on the falling edge after
  // the rising edge that accepted it.
  task automatic drive(input logic [255:0] d, input logic sop, input logic aad,
                       input logic sl, input logic eop, input logic [1:0] m,
                       input logic [3:0] nb);
    int w;
    i_data_bus = d; i_sop = sop; i_is_aad = aad; i_seg_last = sl;
    i_eop = eop; i_blk_mask = m; i_last_nbytes = nb; i_valid = 1'b1;
    w = 0;
    while (o_ready !== 1'b1 && w < 20) begin
      @(negedge i_clock);
      w++;
    end
    if (o_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL drive_ready_timeout got=%b required=1", o_ready);
    end
    @(negedge i_clock);
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_valid = 1'b0; i_data_bus = '0; i_sop = 0; i_is_aad = 0;
    i_seg_last = 0; i_eop = 0; i_blk_mask = 0; i_last_nbytes = 0;
    repeat (3) @(negedge i_clock);
    i_reset = 1'b0;
    @(negedge i_clock);
    n_vec++;
    if ({o_valid, o_sop, o_last, o_ready, o_proto_err} !== 5'b00010) begin
      n_err++;
      $display("FAIL reset_ctrl got=%b required=00010", {o_valid, o_sop, o_last, o_ready, o_proto_err});
    end
    n_vec++;
    if (o_skip_bus !== 2'b11) begin
      n_err++;
      $display("FAIL reset_skip got=%b required=11", o_skip_bus);
    end
    n_vec++;
    if (o_data_x_bus !== 256'd0) begin
      n_err++;
      $display("FAIL reset_data got=%h required=0", o_data_x_bus);
    end
  endtask

  task automatic test_aad_text();
    logic [127:0] a0, a1, t0, g;
    int w;
    a0 = rnd128(); a1 = rnd128(); t0 = rnd128(); g = rnd128();
    push_exp({a1, a0}, 1'b1, 2'b00, 1'b0);
    push_exp({64'd256, 64'd40, pad_ref(t0, 5)}, 1'b0, 2'b00, 1'b1);
    drive({a1, a0}, 1, 1, 1, 0, 2'b11, 4'd0);
    drive({g, t0}, 0, 0, 1, 1, 2'b01, 4'd5);
    n_vec++;
    if (o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL aad_text_ready got=%b required=1", o_ready);
    end
    w = 0;
    while (sb.size() != 0 && w < 20) begin @(negedge i_clock); w++; end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL aad_text_drain outstanding=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] b0, b1, b2, b3;
    int w;
    b0 = rnd128(); b1 = rnd128(); b2 = rnd128(); b3 = rnd128();
    push_exp({b1, b0}, 1'b1, 2'b00, 1'b0);
    push_exp({b3, b2}, 1'b0, 2'b00, 1'b0);
    push_exp({128'd0, 64'd0, 64'd512}, 1'b0, 2'b10, 1'b1);
    drive({b1, b0}, 1, 0, 0, 0, 2'b11, 4'd0);
    drive({b3, b2}, 0, 0, 1, 1, 2'b11, 4'd0);
    n_vec++;
    if (o_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_ready_drop got=%b required=0", o_ready);
    end
    @(negedge i_clock);
    n_vec++;
    if (o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ready_restore got=%b required=1", o_ready);
    end
    w = 0;
    while (sb.size() != 0 && w < 20) begin @(negedge i_clock); w++; end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL b2b_drain outstanding=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_empty();
    int w;
    push_exp(256'd0, 1'b1, 2'b10, 1'b1);
    drive({rnd128(), rnd128()}, 1, 0, 1, 1, 2'b00, 4'd0);
    w = 0;
    while (sb.size() != 0 && w < 20) begin @(negedge i_clock); w++; end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL empty_drain outstanding=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_aad_partial();
    logic [127:0] a0;
    int w;
    a0 = rnd128();
    push_exp({64'd24, 64'd0, pad_ref(a0, 3)}, 1'b1, 2'b00, 1'b1);
    drive({rnd128(), a0}, 1, 1, 1, 1, 2'b01, 4'd3);
    w = 0;
    while (sb.size() != 0 && w < 20) begin @(negedge i_clock); w++; end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL aad_partial_drain outstanding=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_mixed();
    logic [127:0] x0, x1, x2, y0, y1;
    int w;
    x0 = rnd128(); x1 = rnd128(); x2 = rnd128(); y0 = rnd128(); y1 = rnd128();
    push_exp({x1, x0}, 1'b1, 2'b00, 1'b0);
    push_exp({128'd0, x2}, 1'b0, 2'b10, 1'b0);
    push_exp({pad_ref(y1, 7), y0}, 1'b0, 2'b00, 1'b0);
    push_exp({128'd0, 64'd384, 64'd184}, 1'b0, 2'b10, 1'b1);
    drive({x1, x0}, 1, 1, 0, 0, 2'b11, 4'd0);
    drive({rnd128(), x2}, 0, 1, 1, 0, 2'b01, 4'd0);
    drive({y1, y0}, 0, 0, 1, 1, 2'b11, 4'd7);
    w = 0;
    while (sb.size() != 0 && w < 20) begin @(negedge i_clock); w++; end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL mixed_drain outstanding=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_abort();
    logic [127:0] c0, c1, d0;
    int w;
    c0 = rnd128(); c1 = rnd128(); d0 = rnd128();
    push_exp({c1, c0}, 1'b1, 2'b00, 1'b0);
    drive({c1, c0}, 1, 0, 0, 0, 2'b11, 4'd0);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
    n_vec++;
    if ({o_valid, o_last, o_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL abort_ctrl got=%b required=001", {o_valid, o_last, o_ready});
    end
    repeat (3) @(negedge i_clock);
    push_exp({64'd0, 64'd128, d0}, 1'b1, 2'b00, 1'b1);
    drive({rnd128(), d0}, 1, 0, 1, 1, 2'b01, 4'd0);
    w = 0;
    while (sb.size() != 0 && w < 20) begin @(negedge i_clock); w++; end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL abort_drain outstanding=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_proto();
`ifdef GHASH_FMT_PROTOCOL_CHECK_EN
    logic [127:0] z0, z1, z2;
    int w;
    z0 = rnd128(); z1 = rnd128(); z2 = rnd128();
    n_vec++;
    if (o_proto_err !== 1'b0) begin
      n_err++;
      $display("FAIL proto_initial got=%b required=0", o_proto_err);
    end
    push_exp({z1, z0}, 1'b1, 2'b00, 1'b0);
    drive({z1, z0}, 1, 0, 0, 0, 2'b11, 4'd0);
    drive({rnd128(), rnd128()}, 0, 1, 0, 0, 2'b11, 4'd0);
    n_vec++;
    if (o_proto_err !== 1'b1) begin
      n_err++;
      $display("FAIL proto_aad_in_text got=%b required=1", o_proto_err);
    end
    push_exp({64'd0, 64'd384, z2}, 1'b0, 2'b00, 1'b1);
    drive({rnd128(), z2}, 0, 0, 1, 1, 2'b01, 4'd0);
    w = 0;
    while (sb.size() != 0 && w < 20) begin @(negedge i_clock); w++; end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL proto_drain outstanding=%0d required=0", sb.size());
      sb.delete();
    end
    n_vec++;
    if (o_proto_err !== 1'b1) begin
      n_err++;
      $display("FAIL proto_sticky got=%b required=1", o_proto_err);
    end
`else
    repeat (2) @(negedge i_clock);
    n_vec++;
    if (o_proto_err !== 1'b0) begin
      n_err++;
      $display("FAIL proto_tied_low got=%b required=0", o_proto_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_aad_text();
    test_back_to_back();
    test_empty();
    test_aad_partial();
    test_mixed();
    test_reset_abort();
    test_proto();
    repeat (3) @(negedge i_clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ghash_input_formatter.md
Name: ghash_input_formatter

Overview:
Upstream feeder for the multi-block GHASH stage. It accepts a GCM message as a stream of N_BLOCKS-wide words, AAD segment first and then ciphertext. It zero-pads the partial last block of each segment and counts AAD and ciphertext bit lengths. It appends the final len(A)||len(C) block and drives the GHASH stage's data bus, sop, valid and skip bus, with registered outputs.

Parameters:
NB_BLOCK, 128, GHASH block width; any other value is a bad configuration.
N_BLOCKS, 2, blocks per bus word.
LOG2_N_BLOCKS, 1, ceil(log2(N_BLOCKS)).
NB_DATA, N_BLOCKS*NB_BLOCK, bus width.
NB_LEN, 64, width of each bit-length counter.

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_data_bus  in  NB_DATA  input blocks; block k at [k*NB_BLOCK +: NB_BLOCK]
i_valid  in  1  input word valid
i_sop  in  1  first word of message
i_is_aad  in  1  word belongs to AAD segment
i_seg_last  in  1  last word of current segment
i_eop  in  1  last word of message
i_blk_mask  in  N_BLOCKS  valid blocks; contiguous from bit 0
i_last_nbytes  in  4  bytes valid in highest valid block when i_seg_last=1; 0 means 16
o_ready  out  1  input accepted when i_valid&&o_ready
o_data_x_bus  out  NB_DATA  to GHASH i_data_x_bus
o_valid  out  1  to GHASH i_valid
o_sop  out  1  to GHASH i_sop
o_skip_bus  out  N_BLOCKS  to GHASH i_skip_bus; ones only at high indices
o_last  out  1  word carries the length block; GHASH o_data_y is final that cycle
o_proto_err  out  1  sticky protocol error (optional feature)

Behaviour:
- Reset values: o_valid=0, o_sop=0, o_last=0, o_skip_bus=all ones, o_data_x_bus=0, o_ready=1, counters=0, state=IDLE, o_proto_err=0.
- Latency: one cycle from accepted input word to output word. No bubbles are inserted except the LEN cycle.
- FSM states: IDLE, AAD, TEXT, LEN.
  - IDLE -> AAD on accepted i_sop&&i_is_aad.
  - IDLE -> TEXT on accepted i_sop&&!i_is_aad.
  - AAD -> TEXT on accepted AAD word with i_seg_last and no i_eop.
  - Any state -> LEN when an i_eop word leaves no free slot.
  - Any state -> IDLE when the length block has been emitted.
- o_sop is asserted only on the first output word of a message, i.e. the word produced from the accepted i_sop word.
- Padding: data is big-endian; byte 0 sits at bits [127:120]. For a partial block with n bytes, bits [127-8n:0] are forced to 0. Invalid blocks are forced to 0 and their skip bit is set.
- Length counting, per accepted word:
  - +128 for each full valid block.
  - +8*n for a partial block.
  - The word's segment (AAD or text) selects which counter is updated.
  - Counters are NB_LEN wide and wrap modulo 2^NB_LEN.
  - Both counters clear on accepted i_sop, before that word's contribution is added.
- Length block = {len_A[63:0], len_C[63:0]}, with len_A in the MSBs.
  - It is computed from the counters including the i_eop word's contribution.
  - If the i_eop word has a free slot (popcount(mask)<N_BLOCKS), the length block goes in the lowest free slot. Its skip bit is cleared and o_last=1 on the same output word.
  - Otherwise o_ready drops for one cycle (registered, in LEN) and a separate word is emitted: length block in slot 0, other slots skipped, o_sop=0, o_last=1.
- Empty message: accepted i_sop&&i_eop with mask=0 gives a single output word with length block 0 in slot 0, o_sop=1, o_last=1.
- Empty text: i_eop on an AAD word is legal; len_C=0.
- i_valid with o_ready=0 is ignored; upstream must hold the word.
- Reset mid-message aborts: state IDLE, counters 0, no length block emitted.

Optional Feature:
GHASH_FMT_PROTOCOL_CHECK_EN:
- Defined: o_proto_err is set (sticky until reset) on any of:
  - i_valid without i_sop in IDLE
  - i_sop outside IDLE
  - i_is_aad word in TEXT
  - non-contiguous i_blk_mask
  - mask=0 without i_eop
  - a non-last word with mask not all ones
- On violation the word is dropped.
- Undefined: o_proto_err is tied 0 and violations give undefined output.

Decomposition:
- Package gcm_pkg holds:
  - NB_BLOCK, NB_LEN constants
  - FSM state typedef/encoding
  - length-block build function
- One sub-module, ghash_block_pad: combinational single-block zero-pad from nbytes. It is instantiated N_BLOCKS times.

Test Plan:
1. AAD 1 full word (2 blocks), text 1 word mask=01 nbytes=5, eop.
   - Outputs: word0 sop, skip=00.
   - word1: slot0 text padded (low 88 bits zero), slot1={64'd256, 64'd40}, skip=00, o_last=1.
   - No ready drop.
2. Text-only 2 full words, eop on word2.
   - o_ready=0 for exactly one cycle.
   - Third output word: slot0={64'd0, 64'd512}, skip=10, o_last=1, o_sop=0.
3. Empty message (sop&eop, mask=00).
   - One output: slot0=128'd0, skip=10, sop=1, last=1.
4. AAD nbytes=3 partial, eop on AAD.
   - len block {64'd24, 64'd0}; pad bits [103:0] zero.
5. Reset asserted mid-text, then new message.
   - No o_last from aborted message.
   - New message lengths start from 0.
6. With GHASH_FMT_PROTOCOL_CHECK_EN:
   - AAD word after text -> o_proto_err=1, word dropped.
   - Without the macro: o_proto_err stays 0.
